hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Register-dependency scoreboard and stall controller for the five-stage ARM pipeline. It tracks, per architectural register, how many issued instructions still have a pending write-back in EX/MEM/WB. It raises `hazard` whenever the instruction in ID reads a pending register; this drives the `hazard` input of the ID stage and freezes IF and the IF/ID register. It also keeps a stall-cycle performance counter and a sticky consistency-error flag.

## Interface
Parameters:
- `REG_ADDR_W`, 4: register address width (16 registers).
- `CNT_W`, 2: per-register pending counter width (max 3 in flight).
- `STALL_CNT_W`, 16: stall performance counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real (non-bubble) instruction.
- `src_1_en`  in  1  instruction reads `src_1` (Rn).
- `src_1`  in  REG_ADDR_W  first source register.
- `two_src`  in  1  instruction reads `src_2` (Rm, or Rd for STR).
- `src_2`  in  REG_ADDR_W  second source register.
- `id_wb_en`  in  1  instruction in ID will write back.
- `id_dest`  in  REG_ADDR_W  its destination register.
- `flush`  in  1  branch taken in EX; ID instruction is squashed this edge.
- `wb_en_in`  in  1  write-back stage writes the register file this cycle.
- `wb_dest`  in  REG_ADDR_W  write-back destination.
- `hazard`  out  1  stall ID/IF; ID emits a bubble.
- `stall_count`  out  STALL_CNT_W  saturating count of cycles with `hazard`=1.
- `sb_error`  out  1  sticky: counter overflow or underflow detected.

## Operation
- State: `pend[r]` (CNT_W bits, r=0..15), `stall_count`, `sb_error`. Reset clears all to 0.
- Retirement: `ret[r] = wb_en_in & (wb_dest==r)`.
- Effective pending: `eff[r] = pend[r] - ret[r]`. The register file writes before reads within a cycle, so a same-cycle retirement already satisfies the reader.
- Hazard (combinational from state and inputs): `hazard = id_valid & ~flush & ((src_1_en & eff[src_1]!=0) | (two_src & eff[src_2]!=0))`.
- Issue: `iss[r] = id_valid & id_wb_en & ~hazard & ~flush & (id_dest==r)`.
- Update per register:
  - `iss` and `ret` both set: count unchanged.
  - `iss` only: +1. If already at max, hold at max and set `sb_error`.
  - `ret` only: -1. If already 0, hold at 0 and set `sb_error`.
- A self-dependent instruction (dest equal to a source) checks its sources against the pre-issue state.
- `stall_count` increments on each cycle with `hazard`=1 and saturates at all-ones.
- `sb_error` stays set until `rst`.
- No special handling for r15; it is scoreboarded like any other register.

## Timing
- `hazard` has zero-cycle latency: it is valid in the same cycle that ID presents sources.
- `pend` and `stall_count` update at the next rising edge.
- A dependent instruction immediately behind a producer stalls 2 cycles (producer in EX, then MEM). It proceeds in the cycle the producer is in WB.
- `flush` has priority: no hazard and no issue are recorded for the squashed instruction.
- Reset mid-operation: all counts are zeroed on the edge. The pipeline is reset on the same edge, so no stale write-backs follow.
- During reset, `hazard` is forced to 0.

## Structure
- Shared constants package/`Constants.v` holds `REGISTER_FILE_ADDRESS_LEN` and `REG_COUNT` (16).
- Natural sub-module: `pend_counter`, one per register. It has inc/dec/rst inputs and a count/overflow/underflow output, and is instantiated 16 times via generate.
- Top level holds the decoders, the hazard compare, and the performance counter.

## Test plan
- Reset: hold `rst` 2 cycles → all `pend`=0, `hazard`=0, `stall_count`=0, `sb_error`=0.
- Issue writer r3; next cycle ID reads `src_1`=3 → `hazard`=1 for 2 cycles, then 0 in the cycle `wb_en_in`=1 with `wb_dest`=3. `stall_count`=2.
- Issue writer r5 with `flush`=1 → `pend[5]` stays 0. A following reader of r5 sees `hazard`=0.
- Same cycle: issue to r7 and retire r7 (with `pend[7]`=1) → `pend[7]` stays 1, `sb_error`=0.
- `two_src`=0 with `src_2`=4 pending → `hazard`=0. Set `two_src`=1 → `hazard`=1.
- `wb_en_in`=1 on r9 with `pend[9]`=0 → `sb_error`=1, `pend[9]`=0, flag held until `rst`.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared constants and types for the register-dependency scoreboard.
//   - REGISTER_FILE_ADDRESS_LEN : width of an architectural register address
//   - REG_COUNT                 : number of architectural registers tracked
//   - cnt_action_t              : what a per-register pending counter does on
//                                 the next edge
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int REGISTER_FILE_ADDRESS_LEN = 4;
    localparam int REG_COUNT                 = 16;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_action_t;

    // Resolve simultaneous increment/decrement requests into one action.
    // An issue and a retirement in the same cycle cancel out.
    function automatic cnt_action_t resolve_action(input logic inc, input logic dec);
        cnt_action_t act;
        act = CNT_HOLD;
        if (inc && !dec) begin
            act = CNT_INC;
        end else if (dec && !inc) begin
            act = CNT_DEC;
        end
        return act;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_pend_counter.sv
// -----------------------------------------------------------------------------
// pend_counter
//   Saturating up/down counter holding the number of in-flight writers of one
//   architectural register.
//   Ports:
//     clk       in   clock
//     rst       in   synchronous active-high reset, clears the count
//     inc       in   a writer of this register issues this cycle
//     dec       in   a writer of this register retires this cycle
//     count     out  current pending count (registered)
//     overflow  out  inc requested while already at max (count held)
//     underflow out  dec requested while already at zero (count held)
// -----------------------------------------------------------------------------
module pend_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    cnt_action_t      action;

    always_comb begin
        action    = resolve_action(inc, dec);
        count_d   = count_q;
        overflow  = 1'b0;
        underflow = 1'b0;
        case (action)
            CNT_INC: begin
                if (count_q == '1) begin
                    overflow = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            CNT_DEC: begin
                if (count_q == '0) begin
                    underflow = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Register-dependency scoreboard and stall controller for the five-stage
//   pipeline. Tracks, per architectural register, how many issued instructions
//   still owe a write-back, and raises hazard when the instruction in ID reads
//   one of those registers.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     id_valid            ID holds a real instruction
//     src_1_en / src_1    first source read enable / address
//     two_src / src_2     second source read enable / address
//     id_wb_en / id_dest  ID instruction writes back / its destination
//     flush               ID instruction is squashed this cycle
//     wb_en_in / wb_dest  write-back stage writes the register file
//     hazard              stall IF/ID, ID emits a bubble (combinational)
//     stall_count         saturating count of cycles with hazard asserted
//     sb_error            sticky pending-counter overflow/underflow flag
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W  = REGISTER_FILE_ADDRESS_LEN,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   src_1_en,
    input  logic [REG_ADDR_W-1:0]  src_1,
    input  logic                   two_src,
    input  logic [REG_ADDR_W-1:0]  src_2,
    input  logic                   id_wb_en,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   flush,
    input  logic                   wb_en_in,
    input  logic [REG_ADDR_W-1:0]  wb_dest,
    output logic                   hazard,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   sb_error
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    logic [CNT_W-1:0]       pend [NUM_REGS];
    logic [NUM_REGS-1:0]    ret_vec;
    logic [NUM_REGS-1:0]    iss_vec;
    logic [NUM_REGS-1:0]    busy_vec;
    logic [NUM_REGS-1:0]    ovf_vec;
    logic [NUM_REGS-1:0]    udf_vec;
    logic                   src_1_busy;
    logic                   src_2_busy;
    logic                   issue_ok;

    logic [STALL_CNT_W-1:0] stall_count_q;
    logic [STALL_CNT_W-1:0] stall_count_d;
    logic                   sb_error_q;
    logic                   sb_error_d;

    // Retirement decode and effective pending state. The register file writes
    // before it is read, so a register retiring this cycle no longer blocks
    // a reader when its last outstanding writer is the one retiring.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            ret_vec[r]  = wb_en_in & (wb_dest == REG_ADDR_W'(r));
            busy_vec[r] = (pend[r] - CNT_W'(ret_vec[r])) != '0;
        end
    end

    // Sources are compared against pre-issue state, so an instruction whose
    // destination equals one of its sources does not stall on itself.
    assign src_1_busy = src_1_en & busy_vec[src_1];
    assign src_2_busy = two_src  & busy_vec[src_2];
    assign hazard     = ~rst & id_valid & ~flush & (src_1_busy | src_2_busy);

    // A stalled or squashed instruction never reaches EX, so it records no
    // pending write.
    assign issue_ok = id_valid & id_wb_en & ~hazard & ~flush;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            iss_vec[r] = issue_ok & (id_dest == REG_ADDR_W'(r));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        pend_counter #(
            .CNT_W (CNT_W)
        ) u_pend_counter (
            .clk       (clk),
            .rst       (rst),
            .inc       (iss_vec[g]),
            .dec       (ret_vec[g]),
            .count     (pend[g]),
            .overflow  (ovf_vec[g]),
            .underflow (udf_vec[g])
        );
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
        sb_error_d = sb_error_q | (|ovf_vec) | (|udf_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            sb_error_q    <= 1'b0;
        end else begin
            stall_count_q <= stall_count_d;
            sb_error_q    <= sb_error_d;
        end
    end

    assign stall_count = stall_count_q;
    assign sb_error    = sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Scoreboard bench: the driver pushes the reference model's expected outputs
//   for every applied cycle; a monitor pops and compares on the falling edge.
//   The stall counter is built narrow so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int SCW     = 6;
    localparam int SAT_MAX = (1 << SCW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           id_valid;
    logic           src_1_en;
    logic [3:0]     src_1;
    logic           two_src;
    logic [3:0]     src_2;
    logic           id_wb_en;
    logic [3:0]     id_dest;
    logic           flush;
    logic           wb_en_in;
    logic [3:0]     wb_dest;
    logic           hazard;
    logic [SCW-1:0] stall_count;
    logic           sb_error;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_ADDR_W  (4),
        .CNT_W       (2),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .src_1_en    (src_1_en),
        .src_1       (src_1),
        .two_src     (two_src),
        .src_2       (src_2),
        .id_wb_en    (id_wb_en),
        .id_dest     (id_dest),
        .flush       (flush),
        .wb_en_in    (wb_en_in),
        .wb_dest     (wb_dest),
        .hazard      (hazard),
        .stall_count (stall_count),
        .sb_error    (sb_error)
    );

    typedef struct {
        bit       v;
        bit       s1en;
        bit [3:0] s1;
        bit       two;
        bit [3:0] s2;
        bit       wben;
        bit [3:0] dest;
        bit       fl;
        bit       wbe;
        bit [3:0] wbd;
        bit       rs;
    } stim_t;

    typedef struct packed {
        logic           hz;
        logic [SCW-1:0] sc;
        logic           er;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: number of outstanding writers per register as plain ints.
    int pend_m[16];
    int stall_m;
    bit err_m;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic stim_t mk(bit v, bit s1en, int s1, bit two, int s2, bit wben,
                                 int dest, bit fl, bit wbe, int wbd, bit rs);
        stim_t s;
        s.v = v; s.s1en = s1en; s.s1 = s1[3:0]; s.two = two; s.s2 = s2[3:0];
        s.wben = wben; s.dest = dest[3:0]; s.fl = fl; s.wbe = wbe; s.wbd = wbd[3:0];
        s.rs = rs;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit model_hazard(stim_t s);
        int e1, e2;
        if (s.rs) return 1'b0;
        e1 = pend_m[s.s1] - ((s.wbe && s.wbd == s.s1) ? 1 : 0);
        e2 = pend_m[s.s2] - ((s.wbe && s.wbd == s.s2) ? 1 : 0);
        return s.v && !s.fl && ((s.s1en && e1 != 0) || (s.two && e2 != 0));
    endfunction

    task automatic model_edge(stim_t s);
        bit h, iss, ret;
        h = model_hazard(s);
        if (s.rs) begin
            foreach (pend_m[r]) pend_m[r] = 0;
            stall_m = 0;
            err_m   = 1'b0;
            return;
        end
        for (int r = 0; r < 16; r++) begin
            iss = s.v && s.wben && !h && !s.fl && (s.dest == r);
            ret = s.wbe && (s.wbd == r);
            if (iss && !ret) begin
                if (pend_m[r] == 3) err_m = 1'b1;
                else pend_m[r]++;
            end else if (ret && !iss) begin
                if (pend_m[r] == 0) err_m = 1'b1;
                else pend_m[r]--;
            end
        end
        if (h && stall_m < SAT_MAX) stall_m++;
    endtask

    // Apply one cycle of inputs, queue the expected response, advance the model.
    task automatic drive(stim_t s);
        exp_t e;
        #1;
        rst = s.rs; id_valid = s.v; src_1_en = s.s1en; src_1 = s.s1;
        two_src = s.two; src_2 = s.s2; id_wb_en = s.wben; id_dest = s.dest;
        flush = s.fl; wb_en_in = s.wbe; wb_dest = s.wbd;
        e.hz = model_hazard(s);
        e.sc = SCW'(stall_m);
        e.er = err_m;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(s);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hazard", int'(hazard), int'(e.hz));
                chk("stall_count", int'(stall_count), int'(e.sc));
                chk("sb_error", int'(sb_error), int'(e.er));
            end
        end
    end

    initial begin : stimulus
        stim_t s, id_instr;
        bit    hold, h;
        int    st_w[3];
        int    st_d[3];

        foreach (pend_m[r]) pend_m[r] = 0;
        stall_m = 0;
        err_m   = 1'b0;
        rst = 1'b1; id_valid = 1'b0; src_1_en = 1'b0; src_1 = '0; two_src = 1'b0;
        src_2 = '0; id_wb_en = 1'b0; id_dest = '0; flush = 1'b0;
        wb_en_in = 1'b0; wb_dest = '0;
        @(posedge clk);

        // Reset held two cycles with a reader present: hazard stays low.
        drive(mk(1, 1, 3, 1, 4, 1, 3, 0, 1, 3, 1));
        drive(mk(1, 1, 3, 1, 4, 1, 3, 0, 0, 0, 1));
        drive(idle());

        // Producer r3, dependent reader right behind: stalls 2 cycles.
        drive(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
        drive(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(1, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0));
        drive(idle());

        // Squashed writer of r5 records nothing.
        drive(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0));
        drive(mk(1, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0));

        // Issue and retire r7 in the same cycle with one already pending.
        drive(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0));
        drive(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0));
        drive(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));

        // Second source only counts when two_src is set; self-dependent issue.
        drive(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
        drive(mk(1, 1, 4, 1, 4, 1, 4, 0, 1, 4, 0));
        drive(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0));
        drive(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));

        // Stall counter saturation: hold a blocked reader of r12.
        drive(mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0));
        for (int i = 0; i < SAT_MAX + 6; i++) drive(mk(1, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Underflow on r9: flag sticks until reset.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0));
        for (int i = 0; i < 4; i++) drive(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(idle());

        // Overflow on r10: fourth outstanding writer.
        for (int i = 0; i < 4; i++) drive(mk(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0));
        drive(mk(1, 1, 10, 0, 0, 0, 0, 0, 1, 10, 0));
        for (int i = 0; i < 3; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0));
        drive(mk(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Randomized pipeline: write-backs come from a modelled EX/MEM/WB shift.
        hold = 1'b0;
        id_instr = idle();
        for (int i = 0; i < 3; i++) begin st_w[i] = 0; st_d[i] = 0; end
        for (int c = 0; c < 800; c++) begin
            if (!hold) begin
                id_instr = mk(($urandom % 10) != 0, ($urandom % 4) != 0, $urandom % 6,
                              $urandom % 2, $urandom % 6, ($urandom % 3) != 0,
                              $urandom % 6, 0, 0, 0, 0);
            end
            s     = id_instr;
            s.fl  = ($urandom % 12) == 0;
            s.rs  = ($urandom % 250) == 0;
            s.wbe = st_w[2] != 0;
            s.wbd = st_d[2][3:0];
            h     = model_hazard(s);
            drive(s);
            if (s.rs) begin
                for (int i = 0; i < 3; i++) begin st_w[i] = 0; st_d[i] = 0; end
                hold = 1'b0;
            end else begin
                st_w[2] = st_w[1]; st_d[2] = st_d[1];
                st_w[1] = st_w[0]; st_d[1] = st_d[0];
                st_w[0] = (s.v && s.wben && !h && !s.fl) ? 1 : 0;
                st_d[0] = int'(s.dest);
                hold = h;
            end
        end
        drive(idle());

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
